// File: rtl/instruction_fetch.sv
// instruction_fetch: generates the instruction-memory byte address, captures
// the returned word with its PC into a small FIFO and hands the head entry to
// decode over valid/ready. Handles redirects, halt requests and address wrap
// inside the MEM_BYTES window.
// Optional feature macro: FETCH_PERF_CNT_EN adds perf_fetched / perf_stall.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 32,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        misalign_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int               PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int               CNT_W     = PTR_W + 1;
  localparam logic [31:0]      ADDR_MASK = 32'(MEM_BYTES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [63:0]      r_buf [BUF_DEPTH];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [CNT_W-1:0] r_count;
  logic             r_misalign;

  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic [31:0]      w_pcInc;
  logic [31:0]      w_redirTarget;
  logic [63:0]      w_head;

  assign w_full        = (r_count == FULL_CNT);
  assign out_valid     = (r_count != '0);
  assign w_pop         = out_valid && out_ready;
  assign w_push        = (r_state == RUN) && !halt_req && !redirect_valid && (!w_full || w_pop);
  assign w_pcInc       = (r_pc + 32'd4) & ADDR_MASK;
  assign w_redirTarget = {redirect_pc[31:2], 2'b00} & ADDR_MASK;
  assign w_head        = r_buf[r_rdPtr];

  assign imem_pc      = r_pc;
  assign out_pc       = out_valid ? w_head[63:32] : 32'd0;
  assign out_instr    = out_valid ? w_head[31:0]  : 32'd0;
  assign misalign_err = r_misalign;

  // Control FSM: WARMUP holds one cycle, afterwards halt_req alone picks RUN or HALTED
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= WARMUP;
    end else begin
      r_state <= halt_req ? HALTED : RUN;
    end
  end

  // PC register: redirect wins, otherwise advance (with window wrap) only on a push
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= w_redirTarget;
    end else if (w_push) begin
      r_pc <= w_pcInc;
    end
  end

  // Fetch FIFO: a redirect flushes it; a same-cycle pop is still delivered to decode
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_buf[r_wrPtr] <= {r_pc, imem_instr};
        r_wrPtr        <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Misalignment flag: one-cycle pulse after a redirect whose target had low bits set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perfFetched;
  logic [31:0] r_perfStall;

  assign perf_fetched = r_perfFetched;
  assign perf_stall   = r_perfStall;

  // Performance counters: pushes, and RUN cycles lost to a full buffer; redirects leave them alone
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perfFetched <= 32'd0;
      r_perfStall   <= 32'd0;
    end else begin
      if (w_push) begin
        r_perfFetched <= r_perfFetched + 32'd1;
      end
      if ((r_state == RUN) && w_full && !w_pop) begin
        r_perfStall <= r_perfStall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scenarios plus randomized traffic for
// instruction_fetch, compared every cycle against a queue-based model.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          MEM_BYTES = 32;
  localparam int          BUF_DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  logic [31:0] mem [8];

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: queue of {pc, instr} pairs plus the next fetch address
  logic [63:0] modelQ [$];
  logic [31:0] modelPc;
  logic        modelMis;
  bit          modelWarm;
  bit          modelPrevHalt;
  logic [31:0] modelFetched;
  logic [31:0] modelStall;

  instruction_fetch #(
    .RESET_PC (RESET_PC),
    .MEM_BYTES(MEM_BYTES),
    .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_pc       (imem_pc),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt_req      (halt_req),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .misalign_err  (misalign_err)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stall    (perf_stall)
`endif
  );

  // Combinational instruction memory
  assign imem_instr = mem[imem_pc[4:2]];

  // Free-running clock
  always #5 clk = ~clk;

  // Watchdog so the run always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    modelQ.delete();
    modelPc       = RESET_PC;
    modelMis      = 1'b0;
    modelWarm     = 1'b0;
    modelPrevHalt = 1'b0;
    modelFetched  = 32'd0;
    modelStall    = 32'd0;
  endtask

  // Compare every DUT output against the model
  task automatic checkOutput();
    checkValue("imem_pc", imem_pc, modelPc);
    checkValue("out_valid", {31'd0, out_valid}, {31'd0, (modelQ.size() > 0)});
    if (modelQ.size() > 0) begin
      checkValue("out_pc", out_pc, modelQ[0][63:32]);
      checkValue("out_instr", out_instr, modelQ[0][31:0]);
    end
    checkValue("misalign_err", {31'd0, misalign_err}, {31'd0, modelMis});
`ifdef FETCH_PERF_CNT_EN
    checkValue("perf_fetched", perf_fetched, modelFetched);
    checkValue("perf_stall", perf_stall, modelStall);
`endif
  endtask

  // Drive one cycle of inputs at a negedge, advance the model, then check at the next negedge
  task automatic applyStimulus(input logic halt, input logic redir, input logic [31:0] rpc, input logic ready);
    bit pop;
    bit running;
    bit full;
    bit push;
    halt_req       = halt;
    redirect_valid = redir;
    redirect_pc    = rpc;
    out_ready      = ready;
    pop     = (modelQ.size() > 0) && ready;
    running = modelWarm && !modelPrevHalt;
    full    = (modelQ.size() == BUF_DEPTH);
    push    = running && !halt && !redir && (!full || pop);
    if (push) modelFetched = modelFetched + 32'd1;
    if (running && full && !pop) modelStall = modelStall + 32'd1;
    if (pop) void'(modelQ.pop_front());
    if (redir) begin
      modelQ.delete();
      modelPc  = {rpc[31:2], 2'b00} % 32'(MEM_BYTES);
      modelMis = (rpc[1:0] != 2'b00);
    end else begin
      modelMis = 1'b0;
      if (push) begin
        modelQ.push_back({modelPc, mem[modelPc[4:2]]});
        modelPc = (modelPc + 32'd4) % 32'(MEM_BYTES);
      end
    end
    modelPrevHalt = halt;
    modelWarm     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  // Assert reset between edges and confirm the outputs clear without a clock
  task automatic pulseReset();
    #2 reset = 1'b0;
    #1;
    checkValue("async rst imem_pc", imem_pc, RESET_PC);
    checkValue("async rst out_valid", {31'd0, out_valid}, 32'd0);
    checkValue("async rst out_pc", out_pc, 32'd0);
    checkValue("async rst out_instr", out_instr, 32'd0);
    checkValue("async rst misalign_err", {31'd0, misalign_err}, 32'd0);
    modelReset();
  endtask

  task automatic releaseReset();
    @(negedge clk);
    reset = 1'b1;
    modelReset();
  endtask

  // Directed scenarios followed by randomized traffic
  initial begin
    logic        h;
    logic        r;
    logic        rd;
    logic [31:0] p;
    logic        lastHalt;

    mem[0] = 32'h00940333;
    mem[1] = 32'h413903b3;
    mem[2] = 32'h0062e233;
    mem[3] = 32'h40b50533;
    mem[4] = 32'h00c5f5b3;
    mem[5] = 32'h01bd5f33;
    mem[6] = 32'h00a00093;
    mem[7] = 32'hfff00113;

    reset          = 1'b0;
    halt_req       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    out_ready      = 1'b1;
    modelReset();

    #12;
    checkValue("reset imem_pc", imem_pc, 32'h0);
    checkValue("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkValue("reset out_pc", out_pc, 32'd0);
    checkValue("reset out_instr", out_instr, 32'd0);
    checkValue("reset misalign_err", {31'd0, misalign_err}, 32'd0);

    // Reset release with decode always ready
    releaseReset();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkValue("warmup out_valid", {31'd0, out_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkValue("first out_valid", {31'd0, out_valid}, 32'd1);
    checkValue("first out_pc", out_pc, 32'h0);
    checkValue("first out_instr", out_instr, 32'h00940333);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkValue("second out_pc", out_pc, 32'h4);
    checkValue("second out_instr", out_instr, 32'h413903b3);

    // Backpressure from reset: buffer fills with PCs 0 and 4, fetch sticks at 8
    pulseReset();
    releaseReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkValue("stall imem_pc", imem_pc, 32'h8);
    checkValue("stall head pc", out_pc, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkValue("drain pc 4", out_pc, 32'h4);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkValue("drain pc 8", out_pc, 32'h8);

    // Redirect with a full buffer
    applyStimulus(1'b0, 1'b1, 32'h14, 1'b0);
    checkValue("redirect flush valid", {31'd0, out_valid}, 32'd0);
    checkValue("redirect imem_pc", imem_pc, 32'h14);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkValue("redirect out_pc", out_pc, 32'h14);
    checkValue("redirect out_instr", out_instr, 32'h01bd5f33);

    // Misaligned redirect target
    applyStimulus(1'b0, 1'b1, 32'h0E, 1'b1);
    checkValue("misalign pulse", {31'd0, misalign_err}, 32'd1);
    checkValue("misalign imem_pc", imem_pc, 32'h0C);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkValue("misalign clears", {31'd0, misalign_err}, 32'd0);
    checkValue("misalign out_pc", out_pc, 32'h0C);

    // Wrap at the top of the memory window
    applyStimulus(1'b0, 1'b1, 32'h1C, 1'b1);
    checkValue("wrap start pc", imem_pc, 32'h1C);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkValue("wrap imem_pc", imem_pc, 32'h0);
    checkValue("wrap out_pc", out_pc, 32'h1C);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkValue("after wrap out_pc", out_pc, 32'h0);

    // Halt for four cycles with a full buffer: no pushes, buffer drains
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    checkValue("halt imem_pc", imem_pc, 32'h8);
    checkValue("halt drained", {31'd0, out_valid}, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h10, 1'b1);
    checkValue("halt redirect pc", imem_pc, 32'h10);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkValue("resume out_pc", out_pc, 32'h10);

    // Reset in the middle of traffic
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    pulseReset();
    releaseReset();

    // Randomized traffic; redirects avoid WARMUP and cycles where halt_req changes
    lastHalt = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      h  = ($urandom_range(0, 9) == 0) ? ~lastHalt : lastHalt;
      rd = ($urandom_range(0, 3) != 0);
      p  = 32'($urandom_range(0, 255));
      r  = ($urandom_range(0, 11) == 0) && (h == lastHalt) && modelWarm;
      applyStimulus(h, r, p, rd);
      lastHalt = h;
      if ((i % 700) == 699) begin
        pulseReset();
        releaseReset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
